// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the ROM arbiter.
// Build option: ROM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package rom_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 16;

    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational winner search over a request vector starting at a pointer.
// With ROM_ARB_FIXED_PRIO_EN defined the search always starts at index 0.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = idx_w(NUM_REQ_DEF)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int start;
    int best;
    int best_d;
    int d;

    always_comb begin
`ifdef ROM_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = int'(ptr_i);
`endif
        best   = 0;
        best_d = N;
        d      = 0;
        // Winner is the requester with the smallest forward distance from start
        for (int i = 0; i < N; i++) begin
            d = (i + N - start) % N;
            if (req_i[i] && d < best_d) begin
                best_d = d;
                best   = i;
            end
        end
        any_o = |req_i;
        idx_o = IW'(best);
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = any_o && (best == i);
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one combinational ROM among NUM_REQ requesters, one read per 2 cycles.
// Build option: ROM_ARB_FIXED_PRIO_EN removes the pointer and uses fixed priority.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int IW = idx_w(NUM_REQ);

    state_e               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]        ptr;
    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        win_idx;
    logic                 any_req;
    logic                 xfer;
    logic [ADDR_W-1:0]    win_addr;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (any_req)
    );

    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
    assign xfer      = any_req && state_q == IDLE && !rst;
    assign rom_addr  = rom_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) win_addr = win_addr | req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rom_addr_d  = rom_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d    = READ;
                    rom_addr_d = win_addr;
                    owner_d    = win_idx;
                end
            end
            READ: begin
                state_d    = IDLE;
                rsp_data_d = rom_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    rsp_valid_d[i] = (owner_q == IW'(i));
                end
`ifndef ROM_ARB_FIXED_PRIO_EN
                // Served requester moves to the back of the rotation
                ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rom_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rom_addr_q  <= rom_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed vector table plus randomized run against a cycle model.
// Honours ROM_ARB_FIXED_PRIO_EN for both the table and the model.
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;

    int errs = 0;
    int nchk = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    assign rom_data = 16'hA500 | {12'h000, rom_addr};

    rom_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (4),
        .DATA_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    // Behavioural model: event times in cycle numbers
    int          m_ptr;
    int          m_free;
    int          m_rsp_cyc;
    int          m_owner;
    logic [15:0] m_pend_data;
    logic [15:0] m_data;
    logic [3:0]  m_rom;
    logic [3:0]  m_rom_pend;
    int          m_rom_cyc;

    task automatic model_reset();
        m_ptr     = 0;
        m_free    = cyc + 1;
        m_rsp_cyc = -1;
        m_rom_cyc = -1;
        m_owner   = 0;
        m_data    = 16'h0000;
        m_rom     = 4'h0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_check(input logic r, input logic [3:0] v, input logic [15:0] a);
        logic [3:0] exp_rdy;
        logic [3:0] exp_rsp;
        logic [3:0] wa;
        int         win;
        int         start;
        int         idx;
        exp_rdy = 4'b0;
        exp_rsp = 4'b0;
        win     = -1;
        if (m_rom_cyc == cyc) m_rom = m_rom_pend;
        if (m_rsp_cyc == cyc) begin
            exp_rsp[m_owner] = 1'b1;
            m_data = m_pend_data;
        end
`ifdef ROM_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        if (!r && cyc >= m_free) begin
            for (int k = 0; k < 4; k++) begin
                idx = (start + k) % 4;
                if (win < 0 && v[idx]) win = idx;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        chk("m_rsp_data", 32'(rsp_data), 32'(m_data));
        chk("m_rom_addr", 32'(rom_addr), 32'(m_rom));
        if (r) begin
            model_reset();
        end else if (win >= 0) begin
            wa          = a[win*4 +: 4];
            m_rom_pend  = wa;
            m_rom_cyc   = cyc + 1;
            m_rsp_cyc   = cyc + 2;
            m_owner     = win;
            m_pend_data = 16'hA500 | {12'h000, wa};
            m_free      = cyc + 2;
            m_ptr       = (win + 1) % 4;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] v, input logic [15:0] a,
                        output logic [3:0] s_rdy, output logic [3:0] s_rsp,
                        output logic [15:0] s_dat);
        rst       = r;
        req_valid = v;
        req_addr  = a;
        @(negedge clk);
        s_rdy = req_ready;
        s_rsp = rsp_valid;
        s_dat = rsp_data;
        model_check(r, v, a);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [15:0] a;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        logic [15:0] dat;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] v, input logic [15:0] a,
                                input logic [3:0] rdy, input logic [3:0] rsp,
                                input logic [15:0] dat);
        vec_t e;
        e.r = r; e.v = v; e.a = a; e.rdy = rdy; e.rsp = rsp; e.dat = dat;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [3:0]  s_rdy;
        logic [3:0]  s_rsp;
        logic [15:0] s_dat;
        logic        r;
        logic [3:0]  v;
        logic [15:0] a;

        // Reset held with every requester asking
        for (int i = 0; i < 3; i++) add(1, 4'hF, 16'h4321, 4'h0, 4'h0, 16'h0000);
`ifdef ROM_ARB_FIXED_PRIO_EN
        add(0, 4'b1001, 16'h9005, 4'b0001, 4'h0, 16'h0000);
        add(0, 4'b1001, 16'h9005, 4'h0, 4'h0, 16'h0000);
        add(0, 4'b1001, 16'h9005, 4'b0001, 4'b0001, 16'hA505);
        add(0, 4'b1001, 16'h9005, 4'h0, 4'h0, 16'hA505);
        add(0, 4'b1000, 16'h9005, 4'b1000, 4'b0001, 16'hA505);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'hA505);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'b1000, 16'hA509);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'hA509);
`else
        // Single read from requester 2
        add(0, 4'b0100, 16'h0700, 4'b0100, 4'h0, 16'h0000);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'h0000);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'b0100, 16'hA507);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'hA507);
        // Rotation from pointer 0
        add(1, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'hA507);
        add(0, 4'hF, 16'h4321, 4'b0001, 4'h0, 16'h0000);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h0, 16'h0000);
        add(0, 4'hF, 16'h4321, 4'b0010, 4'b0001, 16'hA501);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h0, 16'hA501);
        add(0, 4'hF, 16'h4321, 4'b0100, 4'b0010, 16'hA502);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h0, 16'hA502);
        add(0, 4'hF, 16'h4321, 4'b1000, 4'b0100, 16'hA503);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h0, 16'hA503);
        add(0, 4'hF, 16'h4321, 4'b0001, 4'b1000, 16'hA504);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h0, 16'hA504);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'b0001, 16'hA501);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'hA501);
        // Requesters 0 and 3 alternate, starting from pointer 1
        add(0, 4'b1001, 16'h9005, 4'b1000, 4'h0, 16'hA501);
        add(0, 4'b1001, 16'h9005, 4'h0, 4'h0, 16'hA501);
        add(0, 4'b1001, 16'h9005, 4'b0001, 4'b1000, 16'hA509);
        add(0, 4'b1001, 16'h9005, 4'h0, 4'h0, 16'hA509);
        add(0, 4'b1001, 16'h9005, 4'b1000, 4'b0001, 16'hA505);
        add(0, 4'b1001, 16'h9005, 4'h0, 4'h0, 16'hA505);
        add(0, 4'b1001, 16'h9005, 4'b0001, 4'b1000, 16'hA509);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'hA509);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'b0001, 16'hA505);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'hA505);
        // Reset while reading for requester 1 drops the response
        add(0, 4'b0010, 16'h0060, 4'b0010, 4'h0, 16'hA505);
        add(1, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'hA505);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'h0000);
        add(0, 4'b0011, 16'h0061, 4'b0001, 4'h0, 16'h0000);
        add(0, 4'b0011, 16'h0061, 4'h0, 4'h0, 16'h0000);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'b0001, 16'hA501);
        add(0, 4'b0000, 16'h0000, 4'h0, 4'h0, 16'hA501);
`endif

        rst       = 1'b1;
        req_valid = 4'hF;
        req_addr  = 16'h4321;
        @(posedge clk);
        #1;
        model_reset();

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].a, s_rdy, s_rsp, s_dat);
            chk($sformatf("t%0d_req_ready", i), 32'(s_rdy), 32'(tbl[i].rdy));
            chk($sformatf("t%0d_rsp_valid", i), 32'(s_rsp), 32'(tbl[i].rsp));
            chk($sformatf("t%0d_rsp_data", i), 32'(s_dat), 32'(tbl[i].dat));
        end

        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 49) == 0);
            v = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            step(r, v, a, s_rdy, s_rsp, s_dat);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
